// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared types and width helpers for the data-memory store checker.
//   chk_state_t  : checker FSM states
//   chk_status_t : encoding of the 2-bit status output (STATUS_* constants)
package store_checker_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } chk_state_t;

  typedef enum logic [1:0] {
    STATUS_RUN      = 2'b00,
    STATUS_PASS     = 2'b01,
    STATUS_MISMATCH = 2'b10,
    STATUS_TIMEOUT  = 2'b11
  } chk_status_t;

  // Table index width; a single-entry table still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/store_checker_if.sv
// store_checker_if: control, programming, snoop and result signals of store_checker.
//   master : test controller / core side (drives start, prog_*, memwrite, dataadr, writedata)
//   slave  : the checker (drives done, status, match_cnt, fail_addr, fail_data)
interface store_checker_if
  import store_checker_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CHECKS = 4
);
  localparam int unsigned IDX_W = idx_width(NUM_CHECKS);
  localparam int unsigned CNT_W = cnt_width(NUM_CHECKS);

  logic              start;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_idx;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              done;
  logic [1:0]        status;
  logic [CNT_W-1:0]  match_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  modport master (
    output start, prog_we, prog_idx, prog_addr, prog_data,
    output memwrite, dataadr, writedata,
    input  done, status, match_cnt, fail_addr, fail_data
  );

  modport slave (
    input  start, prog_we, prog_idx, prog_addr, prog_data,
    input  memwrite, dataadr, writedata,
    output done, status, match_cnt, fail_addr, fail_data
  );

endinterface

// File: rtl/store_expect_table.sv
// store_expect_table: NUM_CHECKS-entry table of expected (address, data) stores.
//   clk        : write clock
//   we/widx    : write strobe and entry index (out-of-range index is dropped)
//   waddr/wdata: entry contents
//   ridx       : combinational read index
//   rd_addr_c/rd_data_c : combinational read data
// Contents are intentionally not reset.
module store_expect_table #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [ADDR_W-1:0] addr_mem [NUM_CHECKS];
  logic [DATA_W-1:0] data_mem [NUM_CHECKS];

  // Write port
  always_ff @(posedge clk) begin
    if (we && (32'(widx) < NUM_CHECKS)) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  // Read port
  assign rd_addr_c = addr_mem[ridx];
  assign rd_data_c = data_mem[ridx];

endmodule

// File: rtl/store_checker.sv
// store_checker: snoops the core's data-memory write port and compares stores
// in order against a programmed table of expected (address, data) pairs.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : store_checker_if.slave (start, prog_*, memwrite/dataadr/writedata in;
//           done, status, match_cnt, fail_addr, fail_data out, all registered)
// Optional feature macro STORE_CHECKER_IGNORE_EN: when defined, non-matching
// stores to [IGN_BASE, IGN_BASE+IGN_SIZE) are tolerated instead of failing.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned IGN_BASE       = 80,
  parameter int unsigned IGN_SIZE       = 4
) (
  input logic          clk,
  input logic          reset,
  store_checker_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_CHECKS);
  localparam int unsigned CNT_W = cnt_width(NUM_CHECKS);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHECKS - 1);

  // Elaboration-time parameter sanity checks
  if (NUM_CHECKS < 1) begin : g_bad_num_checks
    $error("store_checker: NUM_CHECKS must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("store_checker: TIMEOUT_CYCLES must be at least 2");
  end
  if ((longint'(IGN_BASE) + longint'(IGN_SIZE)) > (longint'(1) << ADDR_W)) begin : g_bad_window
    $error("store_checker: ignore window exceeds the address space");
  end

  chk_state_t        state_q, state_d;
  chk_status_t       status_q, status_d;
  logic              done_q, done_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  logic              tbl_we_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [ADDR_W-1:0] exp_addr_c;
  logic [DATA_W-1:0] exp_data_c;
  logic              exp_hit_c;
  logic              in_window_c;

  // Table is frozen while a check is running
  assign tbl_we_c = bus.prog_we && (state_q != ARMED);
  assign rd_idx_c = IDX_W'(match_cnt_q);

  store_expect_table #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk       (clk),
    .we        (tbl_we_c),
    .widx      (bus.prog_idx),
    .waddr     (bus.prog_addr),
    .wdata     (bus.prog_data),
    .ridx      (rd_idx_c),
    .rd_addr_c (exp_addr_c),
    .rd_data_c (exp_data_c)
  );

  assign exp_hit_c = (bus.dataadr == exp_addr_c) && (bus.writedata == exp_data_c);

`ifdef STORE_CHECKER_IGNORE_EN
  // One extra bit keeps the window bounds from wrapping at the top of the space
  localparam logic [ADDR_W:0] IGN_LO = (ADDR_W + 1)'(IGN_BASE);
  localparam logic [ADDR_W:0] IGN_HI = (ADDR_W + 1)'(longint'(IGN_BASE) + longint'(IGN_SIZE));

  assign in_window_c = ({1'b0, bus.dataadr} >= IGN_LO) && ({1'b0, bus.dataadr} < IGN_HI);
`else
  assign in_window_c = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      status_q    <= STATUS_RUN;
      done_q      <= 1'b0;
      timer_q     <= '0;
      match_cnt_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      done_q      <= done_d;
      timer_q     <= timer_d;
      match_cnt_q <= match_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    match_cnt_d = match_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    status_d    = STATUS_RUN;
    done_d      = 1'b0;

    case (state_q)
      ARMED: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.memwrite && exp_hit_c) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
          if (match_cnt_q == CNT_LAST) begin
            state_d = PASS;
          end
        end else if (bus.memwrite && !in_window_c) begin
          state_d     = FAIL;
          fail_addr_d = bus.dataadr;
          fail_data_d = bus.writedata;
        end
        // A completing match or a mismatch on the last timer cycle takes precedence
        if ((state_d == ARMED) && (timer_q == TMR_LAST)) begin
          state_d = TIMEOUT;
        end
      end
      default: begin
        if (bus.start) begin
          state_d     = ARMED;
          timer_d     = '0;
          match_cnt_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
    endcase

    case (state_d)
      PASS:    begin status_d = STATUS_PASS;     done_d = 1'b1; end
      FAIL:    begin status_d = STATUS_MISMATCH; done_d = 1'b1; end
      TIMEOUT: begin status_d = STATUS_TIMEOUT;  done_d = 1'b1; end
      default: begin status_d = STATUS_RUN;      done_d = 1'b0; end
    endcase
  end

  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: self-checking bench for store_checker. Two instances:
// dut_a (4 checks, 16-cycle timeout) and dut_b (1 check, 4-cycle timeout).
module tb_store_checker;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NA = 4;
  localparam int unsigned TA = 16;
  localparam int unsigned NB = 1;
  localparam int unsigned TB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_checker_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NA)) ifa ();
  store_checker_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NB)) ifb ();

  store_checker #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NA), .TIMEOUT_CYCLES(TA),
    .IGN_BASE(80), .IGN_SIZE(4)
  ) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));

  store_checker #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NB), .TIMEOUT_CYCLES(TB),
    .IGN_BASE(80), .IGN_SIZE(4)
  ) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: expected table, per-cycle store plan, predicted result
  logic [31:0] m_ea [NA];
  logic [31:0] m_ed [NA];
  bit          pv [TA];
  logic [31:0] pa [TA];
  logic [31:0] pd [TA];
  int          m_k;
  logic [1:0]  m_status;
  int          m_cnt;
  logic [31:0] m_fa, m_fd;

  function automatic bit in_window(input logic [31:0] a);
`ifdef STORE_CHECKER_IGNORE_EN
    return (a >= 32'd80) && (a < 32'd84);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // Walk the ARMED cycles in order and decide the outcome from the rules directly
  function automatic void model_run();
    int cnt;
    cnt = 0;
    m_k = -1; m_status = 2'b00; m_fa = '0; m_fd = '0;
    for (int k = 0; k < int'(TA); k++) begin
      if (m_k < 0 && pv[k]) begin
        if (pa[k] == m_ea[cnt] && pd[k] == m_ed[cnt]) begin
          cnt++;
          if (cnt == int'(NA)) begin m_k = k; m_status = 2'b01; end
        end else if (!in_window(pa[k])) begin
          m_k = k; m_status = 2'b10; m_fa = pa[k]; m_fd = pd[k];
        end
      end
      if (m_k < 0 && k == int'(TA) - 1) begin m_k = k; m_status = 2'b11; end
    end
    m_cnt = cnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.start = 0; ifa.prog_we = 0; ifa.prog_idx = '0; ifa.prog_addr = '0; ifa.prog_data = '0;
    ifa.memwrite = 0; ifa.dataadr = '0; ifa.writedata = '0;
    ifb.start = 0; ifb.prog_we = 0; ifb.prog_idx = '0; ifb.prog_addr = '0; ifb.prog_data = '0;
    ifb.memwrite = 0; ifb.dataadr = '0; ifb.writedata = '0;
  endtask

  task automatic prog_a(input int idx, input logic [31:0] a, input logic [31:0] d);
    ifa.prog_we = 1; ifa.prog_idx = 2'(idx); ifa.prog_addr = a; ifa.prog_data = d;
    tick();
    ifa.prog_we = 0;
  endtask

  task automatic prog_default_a();
    prog_a(0, 32'd84, 32'd71);
    prog_a(1, 32'd92, 32'd5);
    prog_a(2, 32'd96, 32'd1);
    prog_a(3, 32'd100, 32'd2);
  endtask

  task automatic start_a();
    ifa.start = 1; tick(); ifa.start = 0;
  endtask

  task automatic store_a(input logic [31:0] a, input logic [31:0] d);
    ifa.memwrite = 1; ifa.dataadr = a; ifa.writedata = d;
    tick();
    ifa.memwrite = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (ifa.done !== 1'b0) $display("FAIL reset_a_done got=%0b exp=0", ifa.done); else n_pass++;
    n_checks++; if (ifa.status !== 2'b00) $display("FAIL reset_a_status got=%0b exp=00", ifa.status); else n_pass++;
    n_checks++; if (ifa.match_cnt !== 3'd0) $display("FAIL reset_a_cnt got=%0d exp=0", ifa.match_cnt); else n_pass++;
    n_checks++; if (ifa.fail_addr !== 32'd0) $display("FAIL reset_a_faddr got=%0h exp=0", ifa.fail_addr); else n_pass++;
    n_checks++; if (ifa.fail_data !== 32'd0) $display("FAIL reset_a_fdata got=%0h exp=0", ifa.fail_data); else n_pass++;
    n_checks++; if (ifb.done !== 1'b0 || ifb.status !== 2'b00 || ifb.match_cnt !== 1'b0)
      $display("FAIL reset_b got done=%0b status=%0b cnt=%0d exp 0/00/0", ifb.done, ifb.status, ifb.match_cnt);
    else n_pass++;
  endtask

  task automatic test_single_store();
    ifb.prog_we = 1; ifb.prog_idx = 1'b0; ifb.prog_addr = 32'd84; ifb.prog_data = 32'd71;
    tick(); ifb.prog_we = 0;
    ifb.start = 1; tick(); ifb.start = 0;
    n_checks++; if (ifb.status !== 2'b00 || ifb.done !== 1'b0)
      $display("FAIL single_armed got status=%0b done=%0b exp 00/0", ifb.status, ifb.done); else n_pass++;
    ifb.memwrite = 1; ifb.dataadr = 32'd84; ifb.writedata = 32'd71;
    tick(); ifb.memwrite = 0;
    n_checks++; if (ifb.status !== 2'b01) $display("FAIL single_status got=%0b exp=01", ifb.status); else n_pass++;
    n_checks++; if (ifb.done !== 1'b1) $display("FAIL single_done got=%0b exp=1", ifb.done); else n_pass++;
    n_checks++; if (ifb.match_cnt !== 1'b1) $display("FAIL single_cnt got=%0d exp=1", ifb.match_cnt); else n_pass++;
    // Sticky: a bad store after PASS changes nothing
    ifb.memwrite = 1; ifb.dataadr = 32'd4; ifb.writedata = 32'd4;
    tick(); ifb.memwrite = 0;
    n_checks++; if (ifb.status !== 2'b01) $display("FAIL single_sticky got=%0b exp=01", ifb.status); else n_pass++;
  endtask

  task automatic test_final_cycle_match();
    // Match on the last timer cycle wins over timeout
    ifb.start = 1; tick(); ifb.start = 0;
    repeat (TB - 1) tick();
    n_checks++; if (ifb.status !== 2'b00) $display("FAIL lastcyc_pre got=%0b exp=00", ifb.status); else n_pass++;
    ifb.memwrite = 1; ifb.dataadr = 32'd84; ifb.writedata = 32'd71;
    tick(); ifb.memwrite = 0;
    n_checks++; if (ifb.status !== 2'b01) $display("FAIL lastcyc_pass got=%0b exp=01", ifb.status); else n_pass++;
    // Without the store the same cycle times out
    ifb.start = 1; tick(); ifb.start = 0;
    repeat (TB - 1) tick();
    n_checks++; if (ifb.done !== 1'b0) $display("FAIL b_timeout_pre got=%0b exp=0", ifb.done); else n_pass++;
    tick();
    n_checks++; if (ifb.status !== 2'b11) $display("FAIL b_timeout got=%0b exp=11", ifb.status); else n_pass++;
  endtask

  task automatic test_mismatch();
    prog_default_a();
    start_a();
    store_a(32'd88, 32'd71);
    n_checks++; if (ifa.status !== 2'b10) $display("FAIL mis_status got=%0b exp=10", ifa.status); else n_pass++;
    n_checks++; if (ifa.fail_addr !== 32'd88) $display("FAIL mis_faddr got=%0d exp=88", ifa.fail_addr); else n_pass++;
    n_checks++; if (ifa.fail_data !== 32'd71) $display("FAIL mis_fdata got=%0d exp=71", ifa.fail_data); else n_pass++;
    n_checks++; if (ifa.match_cnt !== 3'd0) $display("FAIL mis_cnt got=%0d exp=0", ifa.match_cnt); else n_pass++;
    store_a(32'd84, 32'd71);
    n_checks++; if (ifa.status !== 2'b10 || ifa.match_cnt !== 3'd0)
      $display("FAIL mis_sticky got status=%0b cnt=%0d exp 10/0", ifa.status, ifa.match_cnt); else n_pass++;
  endtask

  task automatic test_ignore_window();
    start_a();
    store_a(32'd80, 32'd7);
    store_a(32'd84, 32'd71);
    store_a(32'd83, 32'd9);
    store_a(32'd84, 32'd0);
`ifdef STORE_CHECKER_IGNORE_EN
    n_checks++; if (ifa.status !== 2'b10) $display("FAIL ign_status got=%0b exp=10", ifa.status); else n_pass++;
    n_checks++; if (ifa.match_cnt !== 3'd1) $display("FAIL ign_cnt got=%0d exp=1", ifa.match_cnt); else n_pass++;
    n_checks++; if (ifa.fail_addr !== 32'd84 || ifa.fail_data !== 32'd0)
      $display("FAIL ign_capture got=%0d/%0d exp=84/0", ifa.fail_addr, ifa.fail_data); else n_pass++;
`else
    n_checks++; if (ifa.status !== 2'b10) $display("FAIL ign_status got=%0b exp=10", ifa.status); else n_pass++;
    n_checks++; if (ifa.match_cnt !== 3'd0) $display("FAIL ign_cnt got=%0d exp=0", ifa.match_cnt); else n_pass++;
    n_checks++; if (ifa.fail_addr !== 32'd80 || ifa.fail_data !== 32'd7)
      $display("FAIL ign_capture got=%0d/%0d exp=80/7", ifa.fail_addr, ifa.fail_data); else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    start_a();
    n_checks++; if (ifa.fail_addr !== 32'd0 || ifa.status !== 2'b00)
      $display("FAIL to_clear got faddr=%0d status=%0b exp 0/00", ifa.fail_addr, ifa.status); else n_pass++;
    repeat (TA - 1) tick();
    n_checks++; if (ifa.status !== 2'b00 || ifa.done !== 1'b0)
      $display("FAIL to_early got status=%0b done=%0b exp 00/0", ifa.status, ifa.done); else n_pass++;
    tick();
    n_checks++; if (ifa.status !== 2'b11) $display("FAIL to_status got=%0b exp=11", ifa.status); else n_pass++;
    n_checks++; if (ifa.done !== 1'b1) $display("FAIL to_done got=%0b exp=1", ifa.done); else n_pass++;
  endtask

  task automatic test_prog_in_armed();
    start_a();
    prog_a(0, 32'd84, 32'd1234);
    store_a(32'd84, 32'd71);
    n_checks++; if (ifa.match_cnt !== 3'd1 || ifa.done !== 1'b0)
      $display("FAIL armed_prog got cnt=%0d done=%0b exp 1/0", ifa.match_cnt, ifa.done); else n_pass++;
    store_a(32'd4, 32'd4);
    n_checks++; if (ifa.status !== 2'b10) $display("FAIL armed_end got=%0b exp=10", ifa.status); else n_pass++;
    prog_a(0, 32'd200, 32'd3);
    start_a();
    store_a(32'd200, 32'd3);
    n_checks++; if (ifa.match_cnt !== 3'd1) $display("FAIL reprog_cnt got=%0d exp=1", ifa.match_cnt); else n_pass++;
    store_a(32'd4, 32'd4);
  endtask

  task automatic test_reset_midtest();
    prog_default_a();
    start_a();
    store_a(32'd84, 32'd71);
    n_checks++; if (ifa.match_cnt !== 3'd1) $display("FAIL rst_pre_cnt got=%0d exp=1", ifa.match_cnt); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++; if (ifa.match_cnt !== 3'd0 || ifa.status !== 2'b00 || ifa.done !== 1'b0 ||
                    ifa.fail_addr !== 32'd0 || ifa.fail_data !== 32'd0)
      $display("FAIL rst_async got cnt=%0d status=%0b done=%0b fa=%0h fd=%0h exp all 0",
               ifa.match_cnt, ifa.status, ifa.done, ifa.fail_addr, ifa.fail_data);
    else n_pass++;
    tick();
    rst_n = 1;
    tick();
    prog_default_a();
    start_a();
    store_a(32'd84, 32'd71);
    store_a(32'd92, 32'd5);
    store_a(32'd96, 32'd1);
    store_a(32'd100, 32'd2);
    n_checks++; if (ifa.status !== 2'b01) $display("FAIL rst_restart_status got=%0b exp=01", ifa.status); else n_pass++;
    n_checks++; if (ifa.match_cnt !== 3'd4) $display("FAIL rst_restart_cnt got=%0d exp=4", ifa.match_cnt); else n_pass++;
  endtask

  // Random back-to-back programs: clean, corrupted, window-polluted or truncated sequences
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int pos, kind, bad, stop;
      for (int i = 0; i < int'(TA); i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end
      for (int i = 0; i < int'(NA); i++) begin
        m_ea[i] = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        m_ed[i] = $urandom;
        prog_a(i, m_ea[i], m_ed[i]);
      end
      kind = int'($urandom_range(0, 3));
      bad  = int'($urandom_range(0, 3));
      stop = int'($urandom_range(0, 3));
      pos  = 0;
      for (int i = 0; i < int'(NA); i++) begin
        if (kind == 3 && i == stop) break;
        pos += int'($urandom_range(0, 1));
        if (kind == 2 && $urandom_range(0, 1) == 1) begin
          pv[pos] = 1; pa[pos] = 32'd80 + 32'($urandom_range(0, 3)); pd[pos] = $urandom; pos++;
        end
        pv[pos] = 1; pa[pos] = m_ea[i]; pd[pos] = m_ed[i];
        if (kind == 1 && i == bad) begin
          if ($urandom_range(0, 1) == 1) pd[pos] ^= 32'd1 << $urandom_range(0, 31);
          else                           pa[pos] ^= 32'd1 << $urandom_range(2, 11);
        end
        pos++;
      end
      if (kind != 3) begin
        for (int j = 0; j < 2; j++) begin pv[pos] = 1; pa[pos] = $urandom; pd[pos] = $urandom; pos++; end
      end
      model_run();

      start_a();
      n_checks++; if (ifa.status !== 2'b00 || ifa.match_cnt !== 3'd0 || ifa.fail_addr !== 32'd0)
        $display("FAIL rnd%0d_start got status=%0b cnt=%0d fa=%0h exp 00/0/0", it, ifa.status, ifa.match_cnt, ifa.fail_addr);
      else n_pass++;
      for (int k = 0; k < int'(TA) + 2; k++) begin
        if (k < int'(TA) && pv[k]) begin
          ifa.memwrite = 1; ifa.dataadr = pa[k]; ifa.writedata = pd[k];
        end else begin
          ifa.memwrite = 0; ifa.dataadr = $urandom; ifa.writedata = $urandom;
        end
        tick();
        n_checks++; if (ifa.done !== (k >= m_k))
          $display("FAIL rnd%0d_done cyc=%0d got=%0b exp=%0b", it, k, ifa.done, (k >= m_k)); else n_pass++;
      end
      ifa.memwrite = 0;
      n_checks++; if (ifa.status !== m_status) $display("FAIL rnd%0d_status got=%0b exp=%0b", it, ifa.status, m_status); else n_pass++;
      n_checks++; if (ifa.match_cnt !== 3'(m_cnt)) $display("FAIL rnd%0d_cnt got=%0d exp=%0d", it, ifa.match_cnt, m_cnt); else n_pass++;
      n_checks++; if (ifa.fail_addr !== m_fa || ifa.fail_data !== m_fd)
        $display("FAIL rnd%0d_capture got=%0h/%0h exp=%0h/%0h", it, ifa.fail_addr, ifa.fail_data, m_fa, m_fd);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) tick();
    test_reset();
    rst_n = 1;
    tick();
    test_single_store();
    test_final_cycle_match();
    test_mismatch();
    test_ignore_window();
    test_timeout();
    test_prog_in_armed();
    test_reset_midtest();
    test_random(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
